// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the valid/allowin pipeline chain.
package pipe_pkg;

  localparam int MIN_STAGES = 2;
  localparam int MAX_STAGES = 16;

  function automatic bit nstage_ok(input int n);
    return (n >= MIN_STAGES) && (n <= MAX_STAGES);
  endfunction

  function automatic int occ_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Stage vectors are zero-extended to 16 bits, so one counter covers every legal depth.
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'b0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline slot: a valid/data register with stall, flush and bubble-collapse logic.
module pipe_stage #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          src_valid,
  input  logic [DW-1:0] src_data,
  input  logic          stall,
  input  logic          flush,
  input  logic          next_allowin,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic          allowin,
  output logic          fwd
);

  logic ready_go;

  assign ready_go = ~stall;
  // A flushed item is masked here so it never reaches the next stage.
  assign fwd      = valid & ready_go & ~flush;
  // An empty slot always accepts, which collapses bubbles.
  assign allowin  = ~valid | (ready_go & next_allowin);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (allowin) begin
      valid <= src_valid;
    end
  end

  // Data is left untouched by flush; only the valid bit matters once killed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (allowin && src_valid) begin
      data <= src_data;
    end
  end

endmodule

// File: rtl/pipe_chain.sv
// N-stage valid/allowin pipeline backbone with per-stage stall/flush taps,
// occupancy and a saturating count of flush-dropped items.
module pipe_chain
  import pipe_pkg::*;
#(
  parameter int DW     = 32,
  parameter int NSTAGE = 5,
  parameter int CNTW   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [DW-1:0]                 in_data,
  output logic                          in_ready,
  input  logic [NSTAGE-1:0]             stall,
  input  logic [NSTAGE-1:0]             flush,
  output logic                          out_valid,
  output logic [DW-1:0]                 out_data,
  input  logic                          out_ready,
  output logic [NSTAGE-1:0]             stage_valid,
  output logic [$clog2(NSTAGE+1)-1:0]   occupancy,
  output logic [CNTW-1:0]               flush_cnt
);

  localparam int OCCW = occ_width(NSTAGE);

  if (!nstage_ok(NSTAGE)) begin : g_bad_nstage
    $error("pipe_chain: NSTAGE must be within 2..16");
  end

  logic [NSTAGE:0]   allowin;
  logic [NSTAGE-1:0] fwd;
  logic [NSTAGE-1:0] valid_q;
  logic [DW-1:0]     data_q [NSTAGE];

  assign allowin[NSTAGE] = out_ready;

  for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
    logic          src_v;
    logic [DW-1:0] src_d;

    if (i == 0) begin : g_head
      assign src_v = in_valid;
      assign src_d = in_data;
    end else begin : g_body
      assign src_v = fwd[i-1];
      assign src_d = data_q[i-1];
    end

    pipe_stage #(.DW(DW)) u_stage (
      .clk          (clk),
      .rst_n        (rst_n),
      .src_valid    (src_v),
      .src_data     (src_d),
      .stall        (stall[i]),
      .flush        (flush[i]),
      .next_allowin (allowin[i+1]),
      .valid        (valid_q[i]),
      .data         (data_q[i]),
      .allowin      (allowin[i]),
      .fwd          (fwd[i])
    );
  end

  assign in_ready    = allowin[0];
  assign out_valid   = fwd[NSTAGE-1];
  assign out_data    = data_q[NSTAGE-1];
  assign stage_valid = valid_q;
  assign occupancy   = OCCW'(popcount16(16'(valid_q)));

  // An accepted item landing in an empty, flushed stage 0 is dropped without
  // ever being held; it is counted separately from the held-item kills.
  logic            in_drop;
  logic [4:0]      drop_now;
  logic [CNTW:0]   cnt_sum;

  assign in_drop  = flush[0] & in_valid & allowin[0] & ~valid_q[0];
  assign drop_now = popcount16(16'(flush & valid_q)) + {4'b0, in_drop};
  assign cnt_sum  = {1'b0, flush_cnt} + (CNTW+1)'(drop_now);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= '0;
    end else if (cnt_sum[CNTW]) begin
      flush_cnt <= '1;
    end else begin
      flush_cnt <= cnt_sum[CNTW-1:0];
    end
  end

endmodule

// File: tb/tb_pipe_chain.sv
// Self-checking bench for pipe_chain: directed scenarios plus a random phase,
// all checked against a slot-array reference model and an ordered scoreboard.
module tb_pipe_chain;

  localparam int DW = 32;
  localparam int NS = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [NS-1:0] stall;
  logic [NS-1:0] flush;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [NS-1:0] stage_valid;
  logic [2:0]    occupancy;
  logic [CW-1:0] flush_cnt;

  always #5 clk = ~clk;

  pipe_chain #(.DW(DW), .NSTAGE(NS), .CNTW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .stall       (stall),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .stage_valid (stage_valid),
    .occupancy   (occupancy),
    .flush_cnt   (flush_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: one slot per stage plus the queue of live items in age order.
  bit          mv [NS];
  logic [31:0] md [NS];
  int unsigned m_cnt;
  logic [31:0] exp_q [$];
  logic [31:0] out_log [$];
  int          out_cyc [$];
  int          cyc = 0;
  int          peak = 0;
  bit          last_acc;
  logic [31:0] next_id;

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
    end
    m_cnt = 0;
    exp_q.delete();
  endtask

  task automatic sb_remove(input logic [31:0] v);
    int idx;
    idx = -1;
    foreach (exp_q[k]) if (idx < 0 && exp_q[k] == v) idx = k;
    check_val("sb_find", 32'(idx >= 0), 1);
    if (idx >= 0) exp_q.delete(idx);
  endtask

  task automatic cycle();
    bit          allow [NS+1];
    bit          fw [NS];
    bit          nv [NS];
    logic [31:0] nd [NS];
    logic [NS-1:0] sv;
    logic [31:0] got;
    int          occ;
    int          add;
    bit          src;
    logic [31:0] sd;
    #1;
    allow[NS] = out_ready;
    for (int i = NS - 1; i >= 0; i--) allow[i] = !mv[i] || (!stall[i] && allow[i+1]);
    occ = 0;
    for (int i = 0; i < NS; i++) begin
      fw[i] = mv[i] && !stall[i] && !flush[i];
      sv[i] = mv[i];
      occ += int'(mv[i]);
    end
    check_val("in_ready", 32'(in_ready), 32'(allow[0]));
    check_val("out_valid", 32'(out_valid), 32'(fw[NS-1]));
    check_val("stage_valid", 32'(stage_valid), 32'(sv));
    check_val("occupancy", 32'(occupancy), 32'(occ));
    check_val("flush_cnt", 32'(flush_cnt), m_cnt);
    if (fw[NS-1]) check_val("out_data", out_data, md[NS-1]);
    if (int'(occupancy) > peak) peak = int'(occupancy);
    if (out_valid && out_ready) begin
      check_val("sb_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        got = exp_q.pop_front();
        check_val("sb_order", out_data, got);
      end
      out_log.push_back(out_data);
      out_cyc.push_back(cyc);
    end
    add = 0;
    for (int i = 0; i < NS; i++) begin
      if (flush[i] && mv[i]) begin
        sb_remove(md[i]);
        add++;
      end
    end
    for (int i = 0; i < NS; i++) begin
      src = (i == 0) ? in_valid : fw[i-1];
      sd  = (i == 0) ? in_data : md[i-1];
      if (allow[i] && src && flush[i]) begin
        if (i == 0) begin
          if (!mv[0]) add++;
        end else begin
          sb_remove(sd);
        end
      end
      nv[i] = flush[i] ? 1'b0 : (allow[i] ? src : mv[i]);
      nd[i] = (allow[i] && src) ? sd : md[i];
    end
    if (in_valid && allow[0] && !flush[0]) exp_q.push_back(in_data);
    last_acc = in_valid && allow[0];
    @(posedge clk);
    mv = nv;
    md = nd;
    m_cnt = (m_cnt + add > 65535) ? 65535 : m_cnt + add;
    cyc++;
    @(negedge clk);
  endtask

  task automatic feed(input int n);
    repeat (n) begin
      in_valid = 1'b1;
      in_data  = next_id;
      cycle();
      if (last_acc) next_id++;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    in_valid  = 1'b0;
    stall     = '0;
    flush     = '0;
    out_ready = 1'b1;
    k = 0;
    while (occupancy != 0 && k < 40) begin
      cycle();
      k++;
    end
    check_val("drain_empty", 32'(occupancy), 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_seq(input string tag, input int n);
    check_val({tag, "_count"}, out_log.size(), n);
    for (int k = 0; k < out_log.size() && k < n; k++) check_val({tag, "_item"}, out_log[k], k + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    logic [31:0] span;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    stall = '0; flush = '0; out_ready = 1'b1;
    model_reset();
    #2;
    check_val("rst_stage_valid", 32'(stage_valid), 0);
    check_val("rst_in_ready", 32'(in_ready), 1);
    check_val("rst_out_valid", 32'(out_valid), 0);
    check_val("rst_flush_cnt", 32'(flush_cnt), 0);
    check_val("rst_occupancy", 32'(occupancy), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back stream, no back-pressure.
    out_log.delete(); out_cyc.delete(); next_id = 1; peak = 0;
    s = cyc;
    feed(8);
    drain();
    check_seq("s1", 8);
    if (out_cyc.size() == 8) begin
      check_val("s1_first_out", out_cyc[0] - s, NS);
      check_val("s1_contiguous", out_cyc[7] - out_cyc[0], 7);
    end
    check_val("s1_peak_occ", peak, NS);

    // Back-pressure fills the chain, then release.
    out_log.delete(); out_cyc.delete(); next_id = 1;
    out_ready = 1'b0;
    feed(10);
    #1;
    check_val("s2_accepted", next_id - 1, NS);
    check_val("s2_in_ready_low", 32'(in_ready), 0);
    out_ready = 1'b1;
    feed(6);
    drain();
    check_seq("s2", int'(next_id) - 1);
    if (out_cyc.size() > 0) check_val("s2_no_gaps", out_cyc[out_cyc.size()-1] - out_cyc[0], out_cyc.size() - 1);

    // Bubble collapse with the output blocked.
    out_log.delete(); out_cyc.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA; cycle();
    in_valid = 1'b0; repeat (3) cycle();
    in_valid = 1'b1; in_data = 32'hB; cycle();
    in_valid = 1'b0; repeat (3) cycle();
    #1;
    check_val("s3_stage_valid", 32'(stage_valid), 32'b11000);
    check_val("s3_occupancy", 32'(occupancy), 2);
    check_val("s3_head_data", out_data, 32'hA);
    drain();
    check_val("s3_count", out_log.size(), 2);
    if (out_log.size() == 2) begin
      check_val("s3_first", out_log[0], 32'hA);
      check_val("s3_second", out_log[1], 32'hB);
    end

    // Three-cycle stall at stage 1 while streaming.
    out_log.delete(); out_cyc.delete(); next_id = 1;
    out_ready = 1'b1;
    feed(6);
    stall = 5'b00010;
    repeat (3) begin
      in_valid = 1'b1;
      in_data  = next_id;
      #1;
      check_val("s4_in_ready_low", 32'(in_ready), 0);
      cycle();
      if (last_acc) next_id++;
    end
    stall = '0;
    feed(4);
    drain();
    check_seq("s4", int'(next_id) - 1);
    if (out_cyc.size() > 0) begin
      span = out_cyc[out_cyc.size()-1] - out_cyc[0] + 1;
      check_val("s4_gap_cycles", span - out_cyc.size(), 3);
    end

    // Flush the three youngest of five held items.
    out_log.delete(); out_cyc.delete(); next_id = 1;
    out_ready = 1'b0;
    feed(5);
    #1;
    check_val("s5_occ_before", 32'(occupancy), 5);
    flush = 5'b00111;
    cycle();
    flush = '0;
    #1;
    check_val("s5_occ_after", 32'(occupancy), 2);
    check_val("s5_flush_cnt", 32'(flush_cnt), 3);
    drain();
    check_seq("s5", 2);

    // Asynchronous reset in the middle of a cycle with four items held.
    out_log.delete(); out_cyc.delete(); next_id = 1;
    out_ready = 1'b0;
    feed(4);
    #1;
    check_val("s6_occ_before", 32'(occupancy), 4);
    in_valid = 1'b1; in_data = next_id;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("s6_stage_valid", 32'(stage_valid), 0);
    check_val("s6_out_valid", 32'(out_valid), 0);
    check_val("s6_in_ready", 32'(in_ready), 1);
    check_val("s6_flush_cnt", 32'(flush_cnt), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_log.delete(); out_cyc.delete(); next_id = 1;
    out_ready = 1'b1;
    feed(4);
    drain();
    check_seq("s6", 4);

    // Random traffic with stalls, flushes and back-pressure.
    apply_reset();
    out_log.delete(); out_cyc.delete(); next_id = 32'h1000;
    repeat (400) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = next_id;
      for (int i = 0; i < NS; i++) begin
        stall[i] = ($urandom_range(0, 7) == 0);
        flush[i] = ($urandom_range(0, 15) == 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      if (last_acc) next_id++;
    end
    drain();
    check_val("rand_sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
